// File: rtl/register_file_arbiter.sv
// Two-requester front end for a single-ported register file.
// Stage A arbitrates combinationally, stage B holds the registered file command,
// stage C returns read data to the requester that issued the read.
// Optional build macro: RF_ARB_FIXED_PRIO_EN selects fixed priority (r0 wins)
// instead of the default round-robin arbitration.
module register_file_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rf_din_o,
  output logic [ADDR_W-1:0] rf_write_o,
  output logic [ADDR_W-1:0] rf_read_o,
  output logic              rf_we_o,
  input  logic [DATA_W-1:0] rf_dout_i,
  output logic              busy_o
);

  logic              gnt0, gnt1, gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Stage B command registers
  logic              b_valid_q, b_valid_d;
  logic              b_rd_q, b_rd_d;
  logic              b_id_q, b_id_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_read_q, rf_read_d;
  logic [DATA_W-1:0] rf_din_q, rf_din_d;

  // Stage C response registers
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef RF_ARB_FIXED_PRIO_EN
  // Fixed priority: r0 always wins, no pointer state.
  always_comb begin
    gnt0 = reset_ni & req0_i;
    gnt1 = reset_ni & req1_i & ~req0_i;
  end
`else
  // Round-robin pointer: 0 means r0 has priority.
  logic ptr_q, ptr_d;

  // Grant the pointer side on contention; move pointer past whoever was granted.
  always_comb begin
    gnt0  = reset_ni & req0_i & (~req1_i | ~ptr_q);
    gnt1  = reset_ni & req1_i & (~req0_i | ptr_q);
    ptr_d = ptr_q;
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Mux the winning requester's command fields.
  always_comb begin
    gnt_any   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1_i    : we0_i;
    sel_addr  = gnt1 ? addr1_i  : addr0_i;
    sel_wdata = gnt1 ? wdata1_i : wdata0_i;
  end

  // Next-state for stages B and C; unused address/data fields hold.
  always_comb begin
    b_valid_d  = gnt_any;
    b_rd_d     = gnt_any & ~sel_we;
    b_id_d     = gnt1;
    rf_we_d    = gnt_any & sel_we;
    rf_write_d = rf_write_q;
    rf_read_d  = rf_read_q;
    rf_din_d   = rf_din_q;
    if (gnt_any) begin
      if (sel_we) begin
        rf_write_d = sel_addr;
        rf_din_d   = sel_wdata;
      end else begin
        rf_read_d  = sel_addr;
      end
    end
    // File read data is sampled at the end of stage B.
    rvalid0_d = b_rd_q & ~b_id_q;
    rvalid1_d = b_rd_q & b_id_q;
    rdata0_d  = rvalid0_d ? rf_dout_i : rdata0_q;
    rdata1_d  = rvalid1_d ? rf_dout_i : rdata1_q;
  end

  // Pipeline registers; reset drops any in-flight command.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      b_valid_q  <= 1'b0;
      b_rd_q     <= 1'b0;
      b_id_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_write_q <= '0;
      rf_read_q  <= '0;
      rf_din_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      b_valid_q  <= b_valid_d;
      b_rd_q     <= b_rd_d;
      b_id_q     <= b_id_d;
      rf_we_q    <= rf_we_d;
      rf_write_q <= rf_write_d;
      rf_read_q  <= rf_read_d;
      rf_din_q   <= rf_din_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Output drive.
  always_comb begin
    gnt0_o     = gnt0;
    gnt1_o     = gnt1;
    rf_we_o    = rf_we_q;
    rf_write_o = rf_write_q;
    rf_read_o  = rf_read_q;
    rf_din_o   = rf_din_q;
    rvalid0_o  = rvalid0_q;
    rvalid1_o  = rvalid1_q;
    rdata0_o   = rdata0_q;
    rdata1_o   = rdata1_q;
    busy_o     = b_valid_q | rvalid0_q | rvalid1_q;
  end

endmodule

// File: tb/tb_register_file_arbiter.sv
// Directed bench for register_file_arbiter with a queue-based read scoreboard.
module tb_register_file_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, rf_we, busy;
  logic [7:0] rdata0, rdata1, rf_din, rf_dout;
  logic [2:0] rf_write, rf_read;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Register file model: reset contents are 8'h10 + index.
  logic [7:0] mem[8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
    end else if (rf_we) begin
      mem[rf_write] <= rf_din;
    end
  end

  assign rf_dout = mem[rf_read];

  register_file_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clock_i   (clk),
    .reset_ni  (rst_n),
    .req0_i    (req0),
    .we0_i     (we0),
    .addr0_i   (addr0),
    .wdata0_i  (wdata0),
    .gnt0_o    (gnt0),
    .rvalid0_o (rvalid0),
    .rdata0_o  (rdata0),
    .req1_i    (req1),
    .we1_i     (we1),
    .addr1_i   (addr1),
    .wdata1_i  (wdata1),
    .gnt1_o    (gnt1),
    .rvalid1_o (rvalid1),
    .rdata1_o  (rdata1),
    .rf_din_o  (rf_din),
    .rf_write_o(rf_write),
    .rf_read_o (rf_read),
    .rf_we_o   (rf_we),
    .rf_dout_i (rf_dout),
    .busy_o    (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever a read response is presented.
  always @(negedge clk) begin
    if (rvalid0) begin
      if (q0.size() == 0) begin
        chk("unexpected_rvalid0", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("rdata0", {24'd0, rdata0}, {24'd0, e.d});
        chk("rvalid0_cycle", cyc, e.c);
      end
    end
    if (rvalid1) begin
      if (q1.size() == 0) begin
        chk("unexpected_rvalid1", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("rdata1", {24'd0, rdata1}, {24'd0, e.d});
        chk("rvalid1_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-stream: read from r0 sits in stage B when reset hits.
    req0 = 1; we0 = 0; addr0 = 3'd2;
    @(negedge clk);
    chk("rst_pre_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    chk("rst_pre_rf_read", {29'd0, rf_read}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt0_gated", {31'd0, gnt0}, 32'd0);
    chk("rst_outs", {rf_din, 5'd0, rf_write, 5'd0, rf_read, 4'd0, rf_we, rvalid0, rvalid1, busy},
        32'd0);
    chk("rst_rdata", {16'd0, rdata0, rdata1}, 32'd0);
    req0 = 0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Contention: both hold read requests for six cycles.
    req0 = 1; we0 = 0; addr0 = 3'd1;
    req1 = 1; we1 = 0; addr1 = 3'd5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef RF_ARB_FIXED_PRIO_EN
      chk("fp_gnt0", {31'd0, gnt0}, 32'd1);
      chk("fp_gnt1", {31'd0, gnt1}, 32'd0);
      q0.push_back('{d: 8'h11, c: cyc + 2});
`else
      chk("rr_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) q0.push_back('{d: 8'h11, c: cyc + 2});
      else            q1.push_back('{d: 8'h15, c: cyc + 2});
`endif
      tick();
    end
`ifdef RF_ARB_FIXED_PRIO_EN
    // r1 only gets served once r0 lets go.
    req0 = 0;
    @(negedge clk);
    chk("fp_gnt1_after", {31'd0, gnt1}, 32'd1);
    q1.push_back('{d: 8'h15, c: cyc + 2});
    tick();
`endif
    req0 = 0; req1 = 0;
    repeat (3) tick();

    // r0 writes addr 3 = 13, then reads it back in the next cycle.
    req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 8'd13;
    @(negedge clk);
    chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    we0 = 0;
    @(negedge clk);
    chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
    chk("wr_rf_we", {31'd0, rf_we}, 32'd1);
    chk("wr_rf_write", {29'd0, rf_write}, 32'd3);
    chk("wr_rf_din", {24'd0, rf_din}, 32'd13);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    q0.push_back('{d: 8'd13, c: cyc + 2});
    tick();
    req0 = 0;
    @(negedge clk);
    chk("rd_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rd_rf_read", {29'd0, rf_read}, 32'd3);
    repeat (3) tick();

    // Hazard: r1 writes addr 7 = 18, r0 reads addr 7 one cycle later.
    req1 = 1; we1 = 1; addr1 = 3'd7; wdata1 = 8'd18;
    @(negedge clk);
    chk("hz_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 3'd7;
    @(negedge clk);
    chk("hz_gnt0", {31'd0, gnt0}, 32'd1);
    q0.push_back('{d: 8'd18, c: cyc + 2});
    tick();
    req0 = 0;
    repeat (4) tick();

    // Idle: nothing in flight, file command fields hold their last values.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_rf_addrs", {5'd0, rf_read, 5'd0, rf_write, rf_din, 8'd0}, {8'd7, 8'd7, 8'd18, 8'd0});
      tick();
    end

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_arbiter.md
Name: register_file_arbiter

Overview:
Shares one register file (DATA_W-bit data, 2^ADDR_W entries, combinational read, write on rising clock edge when enabled) between two requesters, r0 and r1.
- Arbitration is round-robin, with a request/grant handshake.
- Each grant issues exactly one registered command to the file.
- Read data returns with a fixed latency.
- Sits between the CPU datapath / debug port and the register file.

Parameters:
DATA_W, 8, data width of the register file
ADDR_W, 3, register address width (8 entries)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req0  in  1  r0 request; held high until gnt0
we0  in  1  r0 op: 1 = write, 0 = read; valid while req0
addr0  in  ADDR_W  r0 register address
wdata0  in  DATA_W  r0 write data
gnt0  out  1  r0 granted this cycle (combinational)
rvalid0  out  1  r0 read data valid (1-cycle pulse)
rdata0  out  DATA_W  r0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the r0 signals, for r1
rf_din  out  DATA_W  register file write data
rf_write  out  ADDR_W  register file write address
rf_read  out  ADDR_W  register file read address
rf_we  out  1  register file write enable
rf_dout  in  DATA_W  register file read data (combinational from rf_read)
busy  out  1  a command is in flight in stage B or stage C

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs clear to 0: rf_din, rf_write, rf_read, rf_we, rvalid0/1, rdata0/1.
  - Round-robin pointer resets to r0 (r0 has priority first).
  - gnt0/gnt1 are forced to 0 while reset is low.
  - Any in-flight command is dropped: no rvalid and no write after reset is released.
- Stage A, cycle N (arbitration, combinational):
  - Only one requester: it is granted.
  - Both requesting: the pointer side wins.
  - After any grant the pointer moves to the other requester.
  - At most one of gnt0/gnt1 is high per cycle.
  - No grant leaves the pointer unchanged.
- Stage B, cycle N+1 (registered command):
  - Granted write: rf_we=1, rf_write=addr, rf_din=wdata.
  - Granted read: rf_we=0, rf_read=addr.
  - No grant: rf_we=0, rf_read/rf_write/rf_din hold their previous values.
  - rf_we is high for exactly one cycle per granted write.
- Stage C, cycle N+2 (read response):
  - For a read granted in N, rdata<i> holds the value of rf_dout sampled at the end of N+1.
  - rvalid<i> pulses for one cycle in N+2.
  - rdata<i> holds its value until the next read response to that requester.
- Throughput: one grant per cycle; back-to-back grants are fully pipelined.
- Ordering and hazards:
  - A write granted in N updates the file at the end of N+1.
  - A read granted in N+1 or later returns the new value.
  - A read granted in N to the same address as a write granted in N−1 also returns the new value, since it samples at the end of N+1.
  - No forwarding logic is required.
- Requester rules:
  - A requester may drop req without a grant; the request is silently withdrawn.
  - Address and data must be stable while req is high.
- busy = (stage B holds a valid command) OR (stage C holds a valid read).

Optional Feature:
RF_ARB_FIXED_PRIO_EN
- Defined: fixed priority. r0 always wins when both request; the round-robin pointer is removed. r1 may starve.
- Undefined (default): round-robin as described above.
- Pipeline timing is identical in both builds.

Test Plan:
- Reset: reset=0 mid-stream with a read in stage B → all outputs 0, no rvalid0/1 after reset rises, pointer back at r0.
- Single write then read: r0 writes addr 3 = 8'd13, then reads addr 3 → gnt0 in consecutive cycles, rf_we=1 for 1 cycle, rvalid0 two cycles after the read grant with rdata0=13.
- Contention: req0 and req1 held high continuously, both reads → grants alternate r0, r1, r0, r1; each rvalid appears at grant+2.
- Same-address hazard: r1 writes addr 7 = 8'd18 in cycle N, r0 reads addr 7 in cycle N+1 → rdata0=18.
- Idle: no requests for 5 cycles → rf_we=0, busy=0, rf addresses unchanged.
- With RF_ARB_FIXED_PRIO_EN: both requesters held high → gnt0 every cycle, gnt1 never, until req0 drops.
